// File: rtl/uart_to_shk.sv
// UART receiver feeding an address/data shake interface.
// Each frame is an address byte followed by a data byte. Framing, overrun, inter-byte
// timeout and false-start conditions are latched into sticky error flags.
module uart_to_shk #(
  parameter int NB_BAUD_RATE = 115200,
  parameter int NB_SYS_FRE   = 100_000_000,
  parameter int WD_SHK_DATA  = 8,
  parameter int WD_SHK_ADDR  = 8,
  parameter int WD_ERR_INFO  = 4,
  parameter int NB_IDLE_BAUD = 20
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_port_uart_rx,
  output logic                   m_shk_wr_valid,
  output logic [WD_SHK_ADDR-1:0] m_shk_wr_maddr,
  output logic                   m_shk_wr_msync,
  output logic [WD_SHK_DATA-1:0] m_shk_wr_mdata,
  input  logic                   m_shk_wr_ready,
  input  logic                   i_err_clr,
  output logic [WD_ERR_INFO-1:0] m_err_uart_info1
);

  localparam int NB_BAUD_NUMB = NB_SYS_FRE / NB_BAUD_RATE;
  localparam int WD_CNT       = $clog2(NB_BAUD_NUMB + 1);
  localparam int NB_IDLE_CYC  = NB_IDLE_BAUD * NB_BAUD_NUMB;
  localparam int WD_IDLE      = $clog2(NB_IDLE_CYC + 1);

  localparam logic [WD_CNT-1:0]  CNT_HALF  = WD_CNT'(NB_BAUD_NUMB / 2);
  localparam logic [WD_CNT-1:0]  CNT_LAST  = WD_CNT'(NB_BAUD_NUMB - 1);
  localparam logic [WD_IDLE-1:0] IDLE_LAST = WD_IDLE'(NB_IDLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_st_t;
  typedef enum logic [0:0] {F_WAIT_ADDR, F_WAIT_DATA} frm_st_t;

  // Synchronizer
  logic r_rx_meta, r_rx_s;

  // Bit-level receiver state
  bit_st_t               r_bit_st, w_bit_nxt;
  logic [WD_CNT-1:0]     r_cnt, w_cnt_nxt;
  logic [2:0]            r_idx, w_idx_nxt;
  logic [WD_SHK_DATA-1:0] r_shift, w_shift_nxt;
  logic                  r_stop_wait, w_stop_wait_nxt;
  logic                  w_byte_done, w_err_frame, w_err_fstart;

  // Frame-level state and outputs
  frm_st_t               r_frm, w_frm_nxt;
  logic [WD_IDLE-1:0]    r_idle, w_idle_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_msync, w_msync_nxt;
  logic [WD_SHK_ADDR-1:0] r_maddr, w_maddr_nxt;
  logic [WD_SHK_DATA-1:0] r_mdata, w_mdata_nxt;
  logic [WD_ERR_INFO-1:0] r_err, w_err_nxt, w_err_set;

  // Two-flop synchronizer; idle-high reset avoids a phantom start bit
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= s_port_uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Bit FSM next-state: mid-bit sampling, LSB first
  always_comb begin
    w_bit_nxt       = r_bit_st;
    w_cnt_nxt       = r_cnt + 1'b1;
    w_idx_nxt       = r_idx;
    w_shift_nxt     = r_shift;
    w_stop_wait_nxt = r_stop_wait;
    w_byte_done     = 1'b0;
    w_err_frame     = 1'b0;
    w_err_fstart    = 1'b0;
    case (r_bit_st)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_bit_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt = '0;
          w_idx_nxt = '0;
          if (!r_rx_s) begin
            w_bit_nxt = S_DATA;
          end else begin
            w_err_fstart = 1'b1;
            w_bit_nxt    = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[WD_SHK_DATA-1:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_bit_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_stop_wait) begin
          // Broken stop bit: hold off until the line is released
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_stop_wait_nxt = 1'b0;
            w_bit_nxt       = S_IDLE;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_byte_done = 1'b1;
            w_bit_nxt   = S_IDLE;
          end else begin
            w_err_frame     = 1'b1;
            w_stop_wait_nxt = 1'b1;
          end
        end
      end
      default: w_bit_nxt = S_IDLE;
    endcase
  end

  // Bit FSM state register
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_bit_st    <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_stop_wait <= 1'b0;
    end else begin
      r_bit_st    <= w_bit_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_stop_wait <= w_stop_wait_nxt;
    end
  end

  // Frame FSM next-state, output pulses and error collection
  always_comb begin
    w_frm_nxt    = r_frm;
    w_idle_nxt   = r_idle;
    w_valid_nxt  = 1'b0;
    w_msync_nxt  = 1'b0;
    w_maddr_nxt  = r_maddr;
    w_mdata_nxt  = r_mdata;
    w_err_set    = '0;
    w_err_set[0] = w_err_frame;
    w_err_set[3] = w_err_fstart;
    case (r_frm)
      F_WAIT_ADDR: begin
        w_idle_nxt = '0;
        if (w_byte_done) begin
          w_maddr_nxt = r_shift;
          w_valid_nxt = 1'b1;
          w_frm_nxt   = F_WAIT_DATA;
        end
      end
      F_WAIT_DATA: begin
        // Idle timer only runs while no character is in flight
        w_idle_nxt = (r_bit_st == S_IDLE) ? r_idle + 1'b1 : '0;
        if (w_byte_done) begin
          if (m_shk_wr_ready) begin
            w_mdata_nxt = r_shift;
            w_msync_nxt = 1'b1;
          end else begin
            w_err_set[1] = 1'b1;
          end
          w_frm_nxt  = F_WAIT_ADDR;
          w_idle_nxt = '0;
        end else if (w_err_frame) begin
          w_frm_nxt  = F_WAIT_ADDR;
          w_idle_nxt = '0;
        end else if (r_bit_st == S_IDLE && r_idle == IDLE_LAST) begin
          w_err_set[2] = 1'b1;
          w_frm_nxt    = F_WAIT_ADDR;
          w_idle_nxt   = '0;
        end
      end
      default: w_frm_nxt = F_WAIT_ADDR;
    endcase
    // A new error in the clearing cycle survives the clear
    w_err_nxt = (i_err_clr ? '0 : r_err) | w_err_set;
  end

  // Frame FSM and output registers
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_frm   <= F_WAIT_ADDR;
      r_idle  <= '0;
      r_valid <= 1'b0;
      r_msync <= 1'b0;
      r_maddr <= '0;
      r_mdata <= '0;
      r_err   <= '0;
    end else begin
      r_frm   <= w_frm_nxt;
      r_idle  <= w_idle_nxt;
      r_valid <= w_valid_nxt;
      r_msync <= w_msync_nxt;
      r_maddr <= w_maddr_nxt;
      r_mdata <= w_mdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign m_shk_wr_valid   = r_valid;
  assign m_shk_wr_msync   = r_msync;
  assign m_shk_wr_maddr   = r_maddr;
  assign m_shk_wr_mdata   = r_mdata;
  assign m_err_uart_info1 = r_err;

endmodule

// File: tb/tb_uart_to_shk.sv
// Scoreboard bench for uart_to_shk at 10 clocks per bit.
module tb_uart_to_shk;
  localparam int NB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic       clr = 1'b0;
  logic       valid, msync;
  logic [7:0] maddr, mdata;
  logic [3:0] err;

  typedef struct packed {
    logic       is_addr;
    logic [7:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_to_shk #(
    .NB_BAUD_RATE(100_000),
    .NB_SYS_FRE  (1_000_000),
    .WD_SHK_DATA (8),
    .WD_SHK_ADDR (8),
    .WD_ERR_INFO (4),
    .NB_IDLE_BAUD(20)
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .s_port_uart_rx  (rx),
    .m_shk_wr_valid  (valid),
    .m_shk_wr_maddr  (maddr),
    .m_shk_wr_msync  (msync),
    .m_shk_wr_mdata  (mdata),
    .m_shk_wr_ready  (ready),
    .i_err_clr       (clr),
    .m_err_uart_info1(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic a, input logic [7:0] v);
    exp_t e;
    e.is_addr = a;
    e.val     = v;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b = 1'b1);
    rx = 1'b0;
    tick(NB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(NB);
    end
    rx = stop_b;
    tick(NB);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 1000) begin
      tick();
      k++;
    end
    check(name, q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output pulse
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid && msync) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse_overlap: got valid=1 msync=1 expected at most one");
      end
      if (valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: got maddr=0x%0h expected no pulse", maddr);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (!e.is_addr || maddr !== e.val) begin
            n_fail++;
            $display("FAIL valid_maddr: got addr pulse 0x%0h expected %s 0x%0h",
                     maddr, e.is_addr ? "addr" : "data", e.val);
          end
        end
      end
      if (msync) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_msync: got mdata=0x%0h expected no pulse", mdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_addr || mdata !== e.val) begin
            n_fail++;
            $display("FAIL msync_mdata: got data pulse 0x%0h expected %s 0x%0h",
                     mdata, e.is_addr ? "addr" : "data", e.val);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_msync", msync, 0);
    check("rst_maddr", maddr, 0);
    check("rst_mdata", mdata, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick(5);

    // Basic address/data pair
    expect_ev(1'b1, 8'hA5);
    expect_ev(1'b0, 8'h3C);
    send_byte(8'hA5);
    send_byte(8'h3C);
    drain("drain_a5_3c");
    check("err_after_pair", err, 0);

    // Four bytes back-to-back
    expect_ev(1'b1, 8'h12);
    expect_ev(1'b0, 8'h34);
    expect_ev(1'b1, 8'h56);
    expect_ev(1'b0, 8'h78);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    drain("drain_b2b");
    check("maddr_b2b", maddr, 8'h56);
    check("mdata_b2b", mdata, 8'h78);
    check("err_b2b", err, 0);

    // Overrun: sink not ready for the data byte
    expect_ev(1'b1, 8'h01);
    send_byte(8'h01);
    ready = 1'b0;
    send_byte(8'hFF);
    tick(20);
    drain("drain_overrun");
    check("err_overrun", err, 4'b0010);
    check("mdata_held", mdata, 8'h78);
    ready = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("err_cleared", err, 0);

    // Inter-byte timeout: next byte is taken as an address
    expect_ev(1'b1, 8'h01);
    send_byte(8'h01);
    tick(250);
    check("err_timeout", err, 4'b0100);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_ev(1'b1, 8'h02);
    send_byte(8'h02);

    // Framing error right after the address: no pulse, frame restarts
    send_byte(8'h5A, 1'b0);
    tick(50);
    drain("drain_frame");
    check("err_framing", err, 4'b0001);
    check("maddr_after_frame", maddr, 8'h02);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // Short glitch: false start
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(30);
    check("err_false_start", err, 4'b1000);
    check("q_after_glitch", q.size(), 0);

    // Asynchronous reset in bit 4 of 0x55
    rx = 1'b0;
    tick(NB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h55 >> i) & 1;
      tick(NB);
    end
    rx = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    check("arst_maddr", maddr, 0);
    check("arst_mdata", mdata, 0);
    check("arst_err", err, 0);
    check("arst_valid", valid, 0);
    check("arst_msync", msync, 0);
    tick(3);
    rst = 1'b0;
    tick(20);
    expect_ev(1'b1, 8'hAA);
    expect_ev(1'b0, 8'h0F);
    send_byte(8'hAA);
    send_byte(8'h0F);
    drain("drain_after_rst");
    check("err_after_rst", err, 0);

    tick(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
